// File: rtl/m_nibble_serial_adder_ctrl_if.sv
// Request/response bundle between the ALU issue logic (master) and the
// nibble-serial adder sequencer (slave).
interface m_nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 32
) ();
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a source holds valid and its payload
  // stable until that edge, and ready may be asserted independently of valid.
  logic             reqValid_1;
  logic             reqReady_1;
  logic             sub_1;
  logic [WIDTH-1:0] operand1_W;
  logic [WIDTH-1:0] operand2_W;
  logic             respValid_1;
  logic             respReady_1;
  logic [WIDTH-1:0] result_W;
  logic             cOut_1;
  logic             overflow_1;

  modport master (
    output reqValid_1, sub_1, operand1_W, operand2_W, respReady_1,
    input  reqReady_1, respValid_1, result_W, cOut_1, overflow_1
  );

  modport slave (
    input  reqValid_1, sub_1, operand1_W, operand2_W, respReady_1,
    output reqReady_1, respValid_1, result_W, cOut_1, overflow_1
  );
endinterface

// File: rtl/m_nibble_serial_adder_ctrl.sv
// Drives an external 4-bit adder slice one nibble per cycle (LSB first) to
// build a WIDTH-bit add/subtract, rippling the carry through a register.
module m_nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                           i_clk_1,
  input  logic                           i_rst_1,
  m_nibble_serial_adder_ctrl_if.slave    req_if,
  output logic                           o_adderCin_1,
  output logic [3:0]                     o_adderOperand1_4,
  output logic [3:0]                     o_adderOperand2_4,
  input  logic [3:0]                     i_adderResult_4,
  input  logic                           i_adderCout_1,
  output logic [1:0]                     o_dbgState_2
);

  localparam int N     = WIDTH / 4;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH+3:0]   work_shift;

  always_ff @(posedge i_clk_1) begin
    if (i_rst_1) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk_1) begin
    if (i_rst_1) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // New nibbles enter at the top of the working register, so after N
  // captures the LSB nibble has shifted down into bits [3:0].
  assign work_shift = {i_adderResult_4, work_q} >> 4;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_if.reqValid_1) begin
          state_d = S_RUN;
          a_d     = req_if.operand1_W;
          b_d     = req_if.sub_1 ? ~req_if.operand2_W : req_if.operand2_W;
          carry_d = req_if.sub_1;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        work_d  = work_shift[WIDTH-1:0];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = i_adderCout_1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // Operands have shifted so bit 3 is now the sign bit of A and B'.
          state_d  = S_DONE;
          result_d = work_shift[WIDTH-1:0];
          cout_d   = i_adderCout_1;
          ovf_d    = (a_q[3] == b_q[3]) && (i_adderResult_4[3] != a_q[3]);
        end
      end
      S_DONE: begin
        if (req_if.respReady_1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_if.reqReady_1  = (state_q == S_IDLE);
  assign req_if.respValid_1 = (state_q == S_DONE);
  assign req_if.result_W    = result_q;
  assign req_if.cOut_1      = cout_q;
  assign req_if.overflow_1  = ovf_q;

  assign o_adderOperand1_4 = (state_q == S_RUN) ? a_q[3:0] : 4'd0;
  assign o_adderOperand2_4 = (state_q == S_RUN) ? b_q[3:0] : 4'd0;
  assign o_adderCin_1      = (state_q == S_RUN) ? carry_q  : 1'b0;
  assign o_dbgState_2      = state_q;

endmodule
